// File: rtl/lcd_cmd_seq_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, image geometry
// and FSM state encodings.
package lcd_cmd_seq_pkg;

  localparam int LCD_W = 12;
  localparam int LCD_H = 9;
  localparam int NPIX  = LCD_W * LCD_H;

  typedef enum logic [2:0] {
    CMD_LOAD    = 3'd0,
    CMD_ZOOMIN  = 3'd1,
    CMD_ZOOMFIT = 3'd2,
    CMD_RIGHT   = 3'd3,
    CMD_LEFT    = 3'd4,
    CMD_UP      = 3'd5,
    CMD_DOWN    = 3'd6,
    CMD_BAD     = 3'd7
  } cmd_e;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_WAIT_RDY = 4'd3;
  localparam logic [3:0] ST_ISSUE    = 4'd4;
  localparam logic [3:0] ST_STREAM   = 4'd5;
  localparam logic [3:0] ST_WAIT_HI  = 4'd6;
  localparam logic [3:0] ST_WAIT_LO  = 4'd7;
  localparam logic [3:0] ST_FIN      = 4'd8;

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Command/pixel handshake between the sequencer (master) and the LCD controller (slave).
interface lcd_cmd_seq_if;
  import lcd_cmd_seq_pkg::*;

  cmd_e       cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;

  modport master (output cmd, cmd_valid, datain, input busy);
  modport slave  (input cmd, cmd_valid, datain, output busy);

endinterface

// File: rtl/lcd_cmd_seq.sv
// Walks the command script ROM, issues each command to the LCD controller under the
// busy handshake and streams the image on LOAD.
//
// state    | meaning
// IDLE     | waiting for start; done/err hold their last result
// FETCH    | script ROM read latency
// DECODE   | classify entry: end, illegal, or command
// WAIT_RDY | hold until controller is not busy
// ISSUE    | one-cycle cmd_valid strobe
// STREAM   | NPIX pixels on datain, one per cycle
// WAIT_HI  | wait for controller to show busy (accepted)
// WAIT_LO  | wait for busy to drop (complete), advance script
// FIN      | raise done
module lcd_cmd_seq
  import lcd_cmd_seq_pkg::*;
#(
  parameter int SCR_AW = 5,
  parameter int IMG_AW = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [SCR_AW-1:0]  scr_addr,
  input  logic [3:0]         scr_data,
  output logic [IMG_AW-1:0]  img_addr,
  input  logic [7:0]         img_data,
  lcd_cmd_seq_if.master      lcd,
  output logic               done,
  output logic               err
);

  localparam int                 PIX_W    = $clog2(NPIX);
  localparam logic [IMG_AW-1:0]  IMG_LAST = IMG_AW'(NPIX - 1);
  localparam logic [SCR_AW-1:0]  SCR_LAST = '1;

  logic [3:0]       state;
  cmd_e             cur_cmd;
  logic [PIX_W-1:0] pix_cnt;
  logic [7:0]       datain_q;

  // The image address is parked at 0 from DECODE so pixel 0 is already out of the
  // synchronous memory during ISSUE; STREAM then passes img_data straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      scr_addr <= '0;
      img_addr <= '0;
      cur_cmd  <= CMD_LOAD;
      lcd.cmd  <= CMD_LOAD;
      pix_cnt  <= '0;
      datain_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            scr_addr <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          cur_cmd <= cmd_e'(scr_data[2:0]);
          if (scr_data[3]) begin
            state <= ST_FIN;
          end else if (scr_data[2:0] == CMD_BAD) begin
            err   <= 1'b1;
            state <= ST_FIN;
          end else begin
            if (scr_data[2:0] == CMD_LOAD) img_addr <= '0;
            state <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (!lcd.busy) begin
            lcd.cmd <= cur_cmd;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cur_cmd == CMD_LOAD) begin
            img_addr <= img_addr + 1'b1;
            pix_cnt  <= PIX_W'(NPIX - 1);
            state    <= ST_STREAM;
          end else begin
            state <= ST_WAIT_HI;
          end
        end
        ST_STREAM: begin
          datain_q <= img_data;
          if (img_addr != IMG_LAST) img_addr <= img_addr + 1'b1;
          if (pix_cnt == '0) state <= ST_WAIT_HI;
          else               pix_cnt <= pix_cnt - 1'b1;
        end
        ST_WAIT_HI: begin
          if (lcd.busy) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!lcd.busy) begin
            if (scr_addr == SCR_LAST) begin
              state <= ST_FIN;
            end else begin
              scr_addr <= scr_addr + 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lcd.cmd_valid = (state == ST_ISSUE);
  assign lcd.datain    = (state == ST_STREAM) ? img_data : datain_q;

endmodule
